// File: rtl/riscv_pkg.sv
// Shared RV32I core types.
// Trace additions:
//   trace_entry_t : one commit record {pc, instr, result} at the core's native 32-bit width.
//   trace_state_e : capture/readout state of riscv_trace_buffer.
package riscv_pkg;

  localparam int unsigned RvXlen = 32;

  typedef struct packed {
    logic [RvXlen-1:0] pc;
    logic [31:0]       instr;
    logic [RvXlen-1:0] result;
  } trace_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPost,
    StDone
  } trace_state_e;

endpackage

// File: rtl/riscv_trace_ram.sv
// Trace storage: DEPTH entries, one synchronous write port, one asynchronous read port.
// Contents have no reset; they are only exposed while the buffer is in DONE.
// Ports:
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : entry written
//   rd_addr : read index
//   rd_data : entry at rd_addr (combinational)
module riscv_trace_ram
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter type         entry_t = trace_entry_t
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_data
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture buffer. Records the commit stream into a circular buffer after an
// arm pulse, stops POST_TRIG commits after a PC-match trigger, then streams the frozen
// window out oldest-first over valid/ready.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   arm_i                 : (re)start capture, highest priority
//   trig_en_i, trig_pc_i  : PC-match trigger
//   commit_*_i            : commit stream from the core
//   rd_valid_o/rd_ready_i : readout handshake; rd_pc_o/rd_instr_o/rd_result_o entry, rd_last_o
//   busy_o, done_o        : ARMED/POST, DONE
//   count_o, overflow_o   : entries held, pre-trigger history lost
module riscv_trace_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm_i,
  input  logic                       trig_en_i,
  input  logic [XLEN-1:0]            trig_pc_i,
  input  logic                       commit_valid_i,
  input  logic [XLEN-1:0]            commit_pc_i,
  input  logic [31:0]                commit_instr_i,
  input  logic [XLEN-1:0]            commit_result_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [XLEN-1:0]            rd_pc_o,
  output logic [31:0]                rd_instr_o,
  output logic [XLEN-1:0]            rd_result_o,
  output logic                       rd_last_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [CW-1:0] CountOne  = CW'(1);

  // Same layout as trace_entry_t, widened to this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] result;
  } entry_t;

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_cnt_q, post_cnt_d;
  logic          overflow_q, overflow_d;
  logic          wr_en;
  logic [AW-1:0] rd_ptr;
  entry_t        wr_entry, rd_entry;
  logic          in_done;

  // Oldest entry sits count entries behind the write pointer. During readout each handshake
  // decrements count, so this advances by one exactly like an explicit read pointer.
  assign rd_ptr = wr_ptr_q - count_q[AW-1:0];

  assign wr_entry = '{pc: commit_pc_i, instr: commit_instr_i, result: commit_result_i};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (arm_i) begin
      state_d    = StArmed;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StArmed: begin
          if (commit_valid_i) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == CountFull) overflow_d = 1'b1;
            else                      count_d    = count_q + CountOne;
            if (trig_en_i && (commit_pc_i == trig_pc_i)) begin
              if (POST_TRIG == 0) begin
                state_d = StDone;
              end else begin
                state_d    = StPost;
                post_cnt_d = CW'(POST_TRIG);
              end
            end
          end
        end
        StPost: begin
          if (commit_valid_i) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            post_cnt_d = post_cnt_q - CountOne;
            if (count_q == CountFull) overflow_d = 1'b1;
            else                      count_d    = count_q + CountOne;
            if (post_cnt_q == CountOne) state_d = StDone;
          end
        end
        StDone: begin
          if (rd_ready_i) begin
            count_d = count_q - CountOne;
            if (count_q == CountOne) state_d = StIdle;
          end
        end
        StIdle: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  riscv_trace_ram #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  assign in_done     = (state_q == StDone);
  assign rd_valid_o  = in_done;
  assign rd_last_o   = in_done && (count_q == CountOne);
  // Storage is unreset, so data is masked outside DONE.
  assign rd_pc_o     = in_done ? rd_entry.pc     : '0;
  assign rd_instr_o  = in_done ? rd_entry.instr  : '0;
  assign rd_result_o = in_done ? rd_entry.result : '0;
  assign busy_o      = (state_q == StArmed) || (state_q == StPost);
  assign done_o      = in_done;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
module tb_riscv_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_i;
  logic        trig_en_i;
  logic [31:0] trig_pc_i;
  logic        commit_valid_i;
  logic [31:0] commit_pc_i;
  logic [31:0] commit_instr_i;
  logic [31:0] commit_result_i;
  logic        rd_ready_i;

  // POST_TRIG = 2 instance
  logic        rd_valid, rd_last, busy, done, overflow;
  logic [31:0] rd_pc, rd_instr, rd_result;
  logic [3:0]  count;
  // POST_TRIG = 0 instance
  logic        z_rd_valid, z_rd_last, z_busy, z_done, z_overflow;
  logic [31:0] z_rd_pc, z_rd_instr, z_rd_result;
  logic [3:0]  z_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(2)) dut (
    .clk (clk), .rst_n (rst_n), .arm_i (arm_i), .trig_en_i (trig_en_i), .trig_pc_i (trig_pc_i),
    .commit_valid_i (commit_valid_i), .commit_pc_i (commit_pc_i),
    .commit_instr_i (commit_instr_i), .commit_result_i (commit_result_i),
    .rd_valid_o (rd_valid), .rd_ready_i (rd_ready_i), .rd_pc_o (rd_pc), .rd_instr_o (rd_instr),
    .rd_result_o (rd_result), .rd_last_o (rd_last), .busy_o (busy), .done_o (done),
    .count_o (count), .overflow_o (overflow)
  );

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0)) dut_p0 (
    .clk (clk), .rst_n (rst_n), .arm_i (arm_i), .trig_en_i (trig_en_i), .trig_pc_i (trig_pc_i),
    .commit_valid_i (commit_valid_i), .commit_pc_i (commit_pc_i),
    .commit_instr_i (commit_instr_i), .commit_result_i (commit_result_i),
    .rd_valid_o (z_rd_valid), .rd_ready_i (rd_ready_i), .rd_pc_o (z_rd_pc),
    .rd_instr_o (z_rd_instr), .rd_result_o (z_rd_result), .rd_last_o (z_rd_last),
    .busy_o (z_busy), .done_o (z_done), .count_o (z_count), .overflow_o (z_overflow)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1300_0013;
  endfunction

  function automatic logic [31:0] result_of(input logic [31:0] pc);
    return pc + 32'h0000_1000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] pc);
    commit_valid_i  = 1'b1;
    commit_pc_i     = pc;
    commit_instr_i  = instr_of(pc);
    commit_result_i = result_of(pc);
    tick();
    commit_valid_i  = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] pc0, input int n);
    logic [31:0] pc;
    rd_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      pc = pc0 + 32'(4 * i);
      check_eq($sformatf("%s_valid%0d", tag, i), {31'b0, rd_valid}, 32'd1);
      check_eq($sformatf("%s_pc%0d", tag, i), rd_pc, pc);
      check_eq($sformatf("%s_instr%0d", tag, i), rd_instr, instr_of(pc));
      check_eq($sformatf("%s_result%0d", tag, i), rd_result, result_of(pc));
      check_eq($sformatf("%s_last%0d", tag, i), {31'b0, rd_last}, {31'b0, i == n - 1});
      tick();
    end
    rd_ready_i = 1'b0;
  endtask

  task automatic capture_basic();
    trig_en_i = 1'b1;
    trig_pc_i = 32'h8;
    do_arm();
    for (int i = 0; i < 5; i++) do_commit(32'(4 * i));
  endtask

  int idx;

  initial begin
    rst_n = 1'b0; arm_i = 1'b0; trig_en_i = 1'b0; trig_pc_i = '0;
    commit_valid_i = 1'b0; commit_pc_i = '0; commit_instr_i = '0; commit_result_i = '0;
    rd_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_eq("rst_valid", {31'b0, rd_valid}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_count", {28'b0, count}, 32'd0);
    check_eq("rst_ovf", {31'b0, overflow}, 32'd0);

    // Basic capture and readout
    capture_basic();
    check_eq("basic_done", {31'b0, done}, 32'd1);
    check_eq("basic_busy", {31'b0, busy}, 32'd0);
    check_eq("basic_count", {28'b0, count}, 32'd5);
    check_eq("basic_ovf", {31'b0, overflow}, 32'd0);
    read_expect("basic", 32'h0, 5);
    check_eq("basic_idle_done", {31'b0, done}, 32'd0);
    check_eq("basic_idle_valid", {31'b0, rd_valid}, 32'd0);
    check_eq("basic_idle_count", {28'b0, count}, 32'd0);

    // Wrap with overflow
    trig_pc_i = 32'h24;
    do_arm();
    for (int i = 0; i < 12; i++) do_commit(32'(4 * i));
    check_eq("wrap_done", {31'b0, done}, 32'd1);
    check_eq("wrap_count", {28'b0, count}, 32'd8);
    check_eq("wrap_ovf", {31'b0, overflow}, 32'd1);
    read_expect("wrap", 32'h10, 8);

    // Backpressure: ready toggles, each entry must be seen until accepted
    capture_basic();
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      check_eq("bp_valid", {31'b0, rd_valid}, 32'd1);
      check_eq("bp_pc", rd_pc, 32'(4 * idx));
      check_eq("bp_instr", rd_instr, instr_of(32'(4 * idx)));
      rd_ready_i = ((cyc % 2) == 1);
      tick();
      if (rd_ready_i) idx++;
    end
    rd_ready_i = 1'b0;
    check_eq("bp_entries", 32'(idx), 32'd5);
    check_eq("bp_done", {31'b0, done}, 32'd0);

    // No trigger: stays armed, count saturates
    trig_en_i = 1'b0;
    do_arm();
    for (int i = 0; i < 20; i++) do_commit(32'(4 * i));
    check_eq("notrig_busy", {31'b0, busy}, 32'd1);
    check_eq("notrig_done", {31'b0, done}, 32'd0);
    check_eq("notrig_count", {28'b0, count}, 32'd8);
    check_eq("notrig_ovf", {31'b0, overflow}, 32'd1);

    // Commits in DONE are ignored
    trig_en_i = 1'b1;
    trig_pc_i = 32'h100;
    do_arm();
    do_commit(32'h100);
    do_commit(32'h104);
    do_commit(32'h108);
    check_eq("ign_done", {31'b0, done}, 32'd1);
    do_commit(32'h200);
    do_commit(32'h204);
    check_eq("ign_count", {28'b0, count}, 32'd3);
    read_expect("ign", 32'h100, 3);

    // POST_TRIG = 0 instance: trigger on first commit
    trig_pc_i = 32'h40;
    do_arm();
    do_commit(32'h40);
    check_eq("p0_done", {31'b0, z_done}, 32'd1);
    check_eq("p0_count", {28'b0, z_count}, 32'd1);
    check_eq("p0_last", {31'b0, z_rd_last}, 32'd1);
    check_eq("p0_pc", z_rd_pc, 32'h40);
    check_eq("p0_result", z_rd_result, result_of(32'h40));
    check_eq("p2_post_busy", {31'b0, busy}, 32'd1);
    rd_ready_i = 1'b1;
    tick();
    rd_ready_i = 1'b0;
    check_eq("p0_idle_done", {31'b0, z_done}, 32'd0);
    check_eq("p0_idle_count", {28'b0, z_count}, 32'd0);

    // Abort mid-POST; commit in the arm cycle is dropped
    trig_pc_i = 32'h8;
    do_arm();
    do_commit(32'h0);
    do_commit(32'h4);
    do_commit(32'h8);
    check_eq("abort_pre_busy", {31'b0, busy}, 32'd1);
    check_eq("abort_pre_count", {28'b0, count}, 32'd3);
    arm_i = 1'b1;
    commit_valid_i = 1'b1;
    commit_pc_i = 32'h8;
    tick();
    arm_i = 1'b0;
    commit_valid_i = 1'b0;
    check_eq("abort_busy", {31'b0, busy}, 32'd1);
    check_eq("abort_done", {31'b0, done}, 32'd0);
    check_eq("abort_count", {28'b0, count}, 32'd0);
    do_commit(32'h50);
    check_eq("abort_after_count", {28'b0, count}, 32'd1);

    // Reset mid-readout
    capture_basic();
    rd_ready_i = 1'b1;
    tick();
    rd_ready_i = 1'b0;
    check_eq("rstmid_count_pre", {28'b0, count}, 32'd4);
    rst_n = 1'b0;
    tick();
    check_eq("rstmid_valid", {31'b0, rd_valid}, 32'd0);
    check_eq("rstmid_pc", rd_pc, 32'd0);
    check_eq("rstmid_instr", rd_instr, 32'd0);
    check_eq("rstmid_result", rd_result, 32'd0);
    check_eq("rstmid_last", {31'b0, rd_last}, 32'd0);
    check_eq("rstmid_busy", {31'b0, busy}, 32'd0);
    check_eq("rstmid_done", {31'b0, done}, 32'd0);
    check_eq("rstmid_count", {28'b0, count}, 32'd0);
    check_eq("rstmid_ovf", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Parametrised commit-trace capture buffer for the RV32I core. It records the core's per-instruction commit stream (PC, instruction, ALU result) into a circular buffer. Capture starts on an arm pulse and stops a programmable number of commits after a PC-match trigger. The frozen window is then read out oldest-first over a valid/ready stream. It sits beside `riscv_top_core`, fed from its debug commit outputs, and replaces free-running `$display` monitoring with a hardware-observable, synthesizable trace.

## Interface
Parameters:
- `XLEN`, 32, datapath width of PC and result.
- `DEPTH`, 16, number of trace entries; power of two, ≥4.
- `POST_TRIG`, 4, commits captured after the trigger commit; 0 ≤ `POST_TRIG` < `DEPTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `arm_i`  in  1  single-cycle pulse; (re)starts a capture.
- `trig_en_i`  in  1  enables PC-match trigger.
- `trig_pc_i`  in  XLEN  trigger PC.
- `commit_valid_i`  in  1  one instruction committed this cycle.
- `commit_pc_i`  in  XLEN  committed PC.
- `commit_instr_i`  in  32  committed instruction.
- `commit_result_i`  in  XLEN  ALU result.
- `rd_valid_o`  out  1  readout entry valid.
- `rd_ready_i`  in  1  consumer accepts entry.
- `rd_pc_o`, `rd_instr_o`, `rd_result_o`  out  XLEN/32/XLEN  readout entry.
- `rd_last_o`  out  1  current entry is the final one.
- `busy_o`  out  1  state is ARMED or POST.
- `done_o`  out  1  state is DONE.
- `count_o`  out  $clog2(DEPTH)+1  entries held.
- `overflow_o`  out  1  pre-trigger entries were overwritten.

## Operation
States:
- IDLE → ARMED on `arm_i`.
- ARMED → POST on trigger when `POST_TRIG`>0; ARMED → DONE on trigger when `POST_TRIG`==0.
- POST → DONE on the final post-trigger commit.
- DONE → IDLE after the last handshake. DONE with `count_o`==0 is impossible, because the trigger commit is always stored.

Rules:
- `arm_i` has top priority in every state. It clears `wr_ptr`, `count`, `overflow` and `post_cnt` and enters ARMED. It aborts any capture or readout in progress. A commit in the same cycle as `arm_i` is not recorded.
- ARMED: each `commit_valid_i` writes {pc, instr, result} at `wr_ptr`, then `wr_ptr` ← `wr_ptr`+1 mod DEPTH.
- `count` saturates at DEPTH. A write while `count`==DEPTH sets `overflow` (sticky until the next arm or reset).
- Trigger condition: `commit_valid_i` && `trig_en_i` && `commit_pc_i`==`trig_pc_i` while in ARMED. The triggering commit is written. `post_cnt` loads `POST_TRIG`.
- POST: each commit is written and decrements `post_cnt`. The commit that takes `post_cnt` from 1 to 0 moves to DONE. Trigger matches are ignored in POST.
- DONE and IDLE: commits are ignored.
- Readout starts in DONE with `rd_ptr` = `wr_ptr` − `count` mod DEPTH (the oldest entry).
- `rd_valid_o`=1 throughout DONE. On `rd_valid_o && rd_ready_i`: `rd_ptr`+1 mod DEPTH, `count`−1.
- `rd_last_o` = DONE && `count`==1. The handshake on the last entry moves to IDLE.
- Entry data must hold stable while `rd_valid_o && !rd_ready_i`.

## Timing
- Reset (rst_n=0 at a clock edge): state IDLE; all pointers, counters and `overflow` are 0; every output is 0 from that edge on. Storage contents are don't-care, because they are never exposed outside DONE.
- A commit at edge N is stored at edge N and counted in `count_o` after edge N.
- A trigger at edge N with `POST_TRIG`=P sets `done_o` after the edge of the P-th following commit (after edge N when P=0).
- `rd_*` data are combinational from registered `rd_ptr`/state, giving zero-latency readout. One entry per cycle at full throughput.
- `rst_n` low mid-operation aborts everything at that edge.

## Structure
- `riscv_pkg` gains:
  - `trace_entry_t`, a packed struct of pc, instr and result.
  - `trace_state_e`, an enum of IDLE, ARMED, POST, DONE.
- Sub-module `riscv_trace_ram`: DEPTH × `trace_entry_t`, one synchronous write port and one asynchronous read port, with no reset.
- The FSM, pointers and counters live in `riscv_trace_buffer`.

## Test plan
DEPTH=8, POST_TRIG=2 unless stated.
- Basic: arm; commits PC 0x0, 0x4, 0x8 with `trig_pc`=0x8; then commits 0xC, 0x10 → `done_o`=1, `count_o`=5, `overflow_o`=0. Readout PCs are 0x0, 0x4, 0x8, 0xC, 0x10 with `rd_last_o` on 0x10, then IDLE.
- Wrap: 12 commits PC 0x00–0x2C step 4, trigger 0x24 → `count_o`=8, `overflow_o`=1, readout 0x10 through 0x2C in order.
- Backpressure: toggle `rd_ready_i` every cycle during readout → `rd_*` outputs stable while stalled, no entry lost or duplicated.
- No trigger / ignored commits: `trig_en_i`=0 with 20 commits → stays ARMED, `count_o`=8. Commits issued in DONE leave `count_o` and data unchanged.
- POST_TRIG=0: trigger on the first commit → `done_o` after that edge, `count_o`=1, `rd_last_o`=1 immediately.
- Abort: `arm_i` mid-POST → ARMED, `count_o`=0. `rst_n`=0 mid-readout → all outputs 0 after that edge.
